irsram_ctrl: RTL

- Access controller and arbiter in front of the irsram bank array: SRAM_NUM single-port 128x16 macros with shared active-low chip enable and per-bank active-low write enable.
- Shares the array between a word-granular write requester (loader) and a row-granular read requester (compute engine). A read returns the same address from all banks at once.
- Owns all macro control timing and captures the one-cycle-latency read data into a backpressured response register.

---
 rtl/irsram_pkg.sv | 30 +++
 rtl/irsram_rr_arb.sv | 61 ++++++
 rtl/irsram_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/irsram_pkg.sv
// ----------------------------------------------------------------------------
// irsram_pkg
// Shared definitions for the irsram access controller slice: macro geometry,
// the arbitration grant encoding and the controller state encoding.
// Ports: none (package).
// Also provides a default for the SRAM_NUM macro (8 banks) when the build
// does not supply one.
// ----------------------------------------------------------------------------
`ifndef SRAM_NUM
`define SRAM_NUM 8
`endif

package irsram_pkg;

   localparam int IRS_ADDR_W = 7;
   localparam int IRS_DATA_W = 16;
   localparam int IRS_DEPTH  = 128;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WR,
      GNT_RD
   } grant_e;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

endpackage

// File: rtl/irsram_rr_arb.sv
// ----------------------------------------------------------------------------
// irsram_rr_arb
// Two-requester round-robin arbiter (loader writes vs. compute-engine reads)
// with a last-grant register and a read-eligibility mask.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_enable       controller may accept requests this cycle
//   i_wr_valid     write request pending
//   i_rd_valid     read request pending
//   i_rd_ok        read path can take a new read (not in flight, slot free)
//   o_wr_ready     write would be accepted (independent of i_wr_valid)
//   o_rd_ready     read would be accepted (independent of i_rd_valid)
//   o_grant        access granted this cycle
// ----------------------------------------------------------------------------
module irsram_rr_arb
   import irsram_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_enable,
   input  logic   i_wr_valid,
   input  logic   i_rd_valid,
   input  logic   i_rd_ok,
   output logic   o_wr_ready,
   output logic   o_rd_ready,
   output grant_e o_grant
);

   grant_e r_last;
   logic   w_wr_ready;
   logic   w_rd_ready;
   grant_e w_grant;

   // Each ready only looks at the other side's request: a write loses only
   // when an eligible read is waiting and writes had the last turn; a read
   // loses when a write is waiting and reads had the last turn.
   always_comb begin
      w_wr_ready = i_enable && !(i_rd_valid && i_rd_ok && (r_last == GNT_WR));
      w_rd_ready = i_enable && i_rd_ok && !(i_wr_valid && (r_last == GNT_RD));
      w_grant    = GNT_NONE;
      if (i_wr_valid && w_wr_ready) begin
         w_grant = GNT_WR;
      end else if (i_rd_valid && w_rd_ready) begin
         w_grant = GNT_RD;
      end
   end

   // Last grant starts as READ so the first contention goes to the writer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= GNT_RD;
      end else if (w_grant != GNT_NONE) begin
         r_last <= w_grant;
      end
   end

   assign o_wr_ready = w_wr_ready;
   assign o_rd_ready = w_rd_ready;
   assign o_grant    = w_grant;

endmodule

// File: rtl/irsram_ctrl.sv
// ----------------------------------------------------------------------------
// irsram_ctrl
// Access controller in front of SRAM_NUM single-port 128x16 macros. Arbitrates
// word writes from the loader against row reads from the compute engine,
// drives macro control, and captures the one-cycle-latency read data into a
// backpressured response register.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   init_done                       sweep finished (IRSRAM_CTRL_INIT_EN only)
//   wr_valid/wr_ready               write handshake
//   wr_bank, wr_addr, wr_data       write target and data
//   rd_valid/rd_ready, rd_addr      row read handshake and row address
//   rdata_valid/rdata_ready, rdata  row response, bank i in slice i
//   sram_cen, sram_wen              macro chip / write enables (active low)
//   sram_a, sram_d, sram_q          per-bank address, write data, read data
// Optional feature macro: IRSRAM_CTRL_INIT_EN (zero-fill sweep after reset).
// ----------------------------------------------------------------------------
`ifndef SRAM_NUM
`define SRAM_NUM 8
`endif

module irsram_ctrl
   import irsram_pkg::*;
#(
   parameter int SRAM_NUM = `SRAM_NUM,
   parameter int ADDR_W   = IRS_ADDR_W,
   parameter int DATA_W   = IRS_DATA_W,
   parameter int BANK_W   = $clog2(SRAM_NUM)
) (
   input  logic                       clk,
   input  logic                       rst_n,
`ifdef IRSRAM_CTRL_INIT_EN
   output logic                       init_done,
`endif
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [BANK_W-1:0]          wr_bank,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rd_valid,
   output logic                       rd_ready,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic                       rdata_valid,
   input  logic                       rdata_ready,
   output logic [SRAM_NUM*DATA_W-1:0] rdata,
   output logic                       sram_cen,
   output logic [SRAM_NUM-1:0]        sram_wen,
   output logic [SRAM_NUM*ADDR_W-1:0] sram_a,
   output logic [SRAM_NUM*DATA_W-1:0] sram_d,
   input  logic [SRAM_NUM*DATA_W-1:0] sram_q
);

`ifdef IRSRAM_CTRL_INIT_EN
   localparam state_e LP_ST_START = ST_INIT;
`else
   localparam state_e LP_ST_START = ST_RUN;
`endif

   state_e                     r_state;
   state_e                     w_state_nxt;
   logic                       r_live;
   logic                       w_enable;
   logic                       r_inflight;
   logic                       r_rdata_valid;
   logic [SRAM_NUM*DATA_W-1:0] r_rdata;
   logic [SRAM_NUM*ADDR_W-1:0] r_a_hold;
   logic [SRAM_NUM*DATA_W-1:0] r_d_hold;
   logic [SRAM_NUM*ADDR_W-1:0] w_a;
   logic [SRAM_NUM*DATA_W-1:0] w_d;
   logic                       w_cen;
   logic [SRAM_NUM-1:0]        w_wen;
   logic                       w_rd_ok;
   logic                       w_bank_ok;
   logic                       w_wr_ready;
   logic                       w_rd_ready;
   grant_e                     w_grant;
`ifdef IRSRAM_CTRL_INIT_EN
   logic [ADDR_W-1:0]          r_init_addr;
   logic                       r_init_done;
`endif

   // Goes high on the first clock after reset release, so nothing touches
   // the macros or accepts requests while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

`ifdef IRSRAM_CTRL_INIT_EN
   // Zero-fill sweep: one address per cycle; init_done rises together with
   // the move to RUN, right after the last address is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_init_addr <= '0;
         r_init_done <= 1'b0;
      end else if (r_live && (r_state == ST_INIT)) begin
         r_init_addr <= r_init_addr + ADDR_W'(1);
         if (r_init_addr == ADDR_W'(IRS_DEPTH - 1)) begin
            r_init_done <= 1'b1;
         end
      end
   end
   assign w_enable  = r_init_done;
   assign init_done = r_init_done;
`else
   assign w_enable  = r_live;
`endif

   assign w_rd_ok   = !r_inflight && (!r_rdata_valid || rdata_ready);
   assign w_bank_ok = (32'(wr_bank) < 32'(SRAM_NUM));

   irsram_rr_arb u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_enable   (w_enable),
      .i_wr_valid (wr_valid),
      .i_rd_valid (rd_valid),
      .i_rd_ok    (w_rd_ok),
      .o_wr_ready (w_wr_ready),
      .o_rd_ready (w_rd_ready),
      .o_grant    (w_grant)
   );

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LP_ST_START;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and macro control. With no access the address/data buses
   // keep their last driven values; writes to a non-existent bank are
   // accepted upstream but never reach the macros.
   always_comb begin
      w_state_nxt = r_state;
      w_cen       = 1'b1;
      w_wen       = '1;
      w_a         = r_a_hold;
      w_d         = r_d_hold;
      if (r_state == ST_INIT) begin
`ifdef IRSRAM_CTRL_INIT_EN
         if (r_live) begin
            w_cen = 1'b0;
            w_wen = '0;
            w_a   = {SRAM_NUM{r_init_addr}};
            w_d   = '0;
            if (r_init_addr == ADDR_W'(IRS_DEPTH - 1)) begin
               w_state_nxt = ST_RUN;
            end
         end
`endif
      end else if (w_grant == GNT_WR) begin
         if (w_bank_ok) begin
            w_cen = 1'b0;
            for (int i = 0; i < SRAM_NUM; i++) begin
               w_wen[i] = (32'(wr_bank) != 32'(i));
            end
            w_a = {SRAM_NUM{wr_addr}};
            w_d = {SRAM_NUM{wr_data}};
         end
      end else if (w_grant == GNT_RD) begin
         w_cen = 1'b0;
         w_a   = {SRAM_NUM{rd_addr}};
      end
   end

   // Remember the last address/data actually presented to the macros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_hold <= '0;
         r_d_hold <= '0;
      end else if (!w_cen) begin
         r_a_hold <= w_a;
         r_d_hold <= w_d;
      end
   end

   // Read data lands on sram_q the cycle after the read; capture it then.
   // A pending capture always wins over a same-cycle consume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight    <= 1'b0;
         r_rdata_valid <= 1'b0;
         r_rdata       <= '0;
      end else begin
         r_inflight <= (w_grant == GNT_RD);
         if (r_inflight) begin
            r_rdata       <= sram_q;
            r_rdata_valid <= 1'b1;
         end else if (rdata_ready) begin
            r_rdata_valid <= 1'b0;
         end
      end
   end

   assign wr_ready    = w_wr_ready;
   assign rd_ready    = w_rd_ready;
   assign rdata_valid = r_rdata_valid;
   assign rdata       = r_rdata;
   assign sram_cen    = w_cen;
   assign sram_wen    = w_wen;
   assign sram_a      = w_a;
   assign sram_d      = w_d;

endmodule
